// File: rtl/spi_reg_bank_if.sv
// spi_reg_bank_if: register bus between the SPI slave front end and the register bank
interface spi_reg_bank_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [DATA_WIDTH-1:0] reg_wdata;
  logic [DATA_WIDTH-1:0] reg_rdata;
  logic                  reg_write;
  modport master (output reg_addr, reg_wdata, reg_write, input reg_rdata);
  modport slave  (input reg_addr, reg_wdata, reg_write, output reg_rdata);
endinterface

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: ID/CTRL/STATUS/IRQ/WR_COUNT/CFG register bank; IRQ block built only with SPI_REG_BANK_IRQ_EN
module spi_reg_bank #(
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_CFG    = 8,
  parameter int          IRQ_WIDTH  = 8,
  parameter logic [31:0] ID_VALUE   = 32'h5350_0001
) (
  input  logic                          clk,
  input  logic                          rst,
  spi_reg_bank_if.slave                 bus,
  input  logic [DATA_WIDTH-1:0]         status_in,
  input  logic [IRQ_WIDTH-1:0]          irq_evt,
  output logic                          irq,
  output logic                          ctrl_en,
  output logic                          soft_rst,
  output logic [NUM_CFG*DATA_WIDTH-1:0] cfg_regs
);
  localparam logic [ADDR_WIDTH-1:0] A_ID       = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL     = ADDR_WIDTH'(8'h01);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS   = ADDR_WIDTH'(8'h02);
  localparam logic [ADDR_WIDTH-1:0] A_IRQ_STAT = ADDR_WIDTH'(8'h03);
  localparam logic [ADDR_WIDTH-1:0] A_IRQ_MASK = ADDR_WIDTH'(8'h04);
  localparam logic [ADDR_WIDTH-1:0] A_WR_COUNT = ADDR_WIDTH'(8'h05);
  logic                  reg_write_d, commit, wr_ctrl;
  logic [DATA_WIDTH-1:0] ctrl, ctrl_n, status_q, rdata_n;
  logic [DATA_WIDTH-1:0] cfg [NUM_CFG];
  logic [DATA_WIDTH-1:0] cfg_n [NUM_CFG];
  logic [15:0]           wr_count, wr_count_n;
  assign commit  = bus.reg_write & ~reg_write_d;
  assign wr_ctrl = commit && bus.reg_addr == A_CTRL;
  assign ctrl_en = ctrl[0];
  for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg
    assign cfg_regs[k*DATA_WIDTH +: DATA_WIDTH] = cfg[k];
  end
`ifdef SPI_REG_BANK_IRQ_EN
  logic                 wr_stat, wr_mask;
  logic [IRQ_WIDTH-1:0] irq_stat, irq_stat_n, irq_mask, irq_mask_n;
  assign wr_stat = commit && bus.reg_addr == A_IRQ_STAT;
  assign wr_mask = commit && bus.reg_addr == A_IRQ_MASK;
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_stat <= '0;
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      irq_stat <= irq_stat_n;
      irq_mask <= irq_mask_n;
      irq      <= |(irq_stat & irq_mask);
    end
  end
`else
  logic unused_irq_evt;
  assign unused_irq_evt = ^irq_evt;
  assign irq = 1'b0;
`endif
  // Read data is built from next-state values so a read in the commit cycle sees the new contents.
  always_comb begin
    ctrl_n     = wr_ctrl ? {bus.reg_wdata[DATA_WIDTH-1:2], 1'b0, bus.reg_wdata[0]} : ctrl;
    wr_count_n = soft_rst ? '0 : (commit && wr_count != 16'hFFFF) ? wr_count + 16'd1 : wr_count;
    for (int k = 0; k < NUM_CFG; k++)
      cfg_n[k] = (commit && bus.reg_addr == ADDR_WIDTH'(16 + k)) ? bus.reg_wdata : cfg[k];
`ifdef SPI_REG_BANK_IRQ_EN
    irq_stat_n = soft_rst ? '0 : (irq_stat & ~(wr_stat ? bus.reg_wdata[IRQ_WIDTH-1:0] : '0)) | irq_evt;
    irq_mask_n = wr_mask ? bus.reg_wdata[IRQ_WIDTH-1:0] : irq_mask;
`endif
    rdata_n = '0;
    if (bus.reg_addr == A_ID)       rdata_n = DATA_WIDTH'(ID_VALUE);
    if (bus.reg_addr == A_CTRL)     rdata_n = ctrl_n;
    if (bus.reg_addr == A_STATUS)   rdata_n = status_q;
`ifdef SPI_REG_BANK_IRQ_EN
    if (bus.reg_addr == A_IRQ_STAT) rdata_n = DATA_WIDTH'(irq_stat_n);
    if (bus.reg_addr == A_IRQ_MASK) rdata_n = DATA_WIDTH'(irq_mask_n);
`endif
    if (bus.reg_addr == A_WR_COUNT) rdata_n = DATA_WIDTH'(wr_count_n);
    for (int k = 0; k < NUM_CFG; k++)
      if (bus.reg_addr == ADDR_WIDTH'(16 + k)) rdata_n = cfg_n[k];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_d   <= 1'b0;
      ctrl          <= '0;
      status_q      <= '0;
      wr_count      <= '0;
      soft_rst      <= 1'b0;
      cfg           <= '{default: '0};
      bus.reg_rdata <= '0;
    end else begin
      reg_write_d   <= bus.reg_write;
      ctrl          <= ctrl_n;
      status_q      <= status_in;
      wr_count      <= wr_count_n;
      soft_rst      <= wr_ctrl & bus.reg_wdata[1];
      cfg           <= cfg_n;
      bus.reg_rdata <= rdata_n;
    end
  end
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed self-checking bench for spi_reg_bank
module tb_spi_reg_bank;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  status_in;
  logic [7:0]   irq_evt;
  logic         irq, ctrl_en, soft_rst;
  logic [255:0] cfg_regs;
  logic [31:0]  rd;
  int           n_checks = 0;
  int           n_fail = 0;
  spi_reg_bank_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();
  spi_reg_bank dut (
    .clk(clk), .rst(rst), .bus(bus), .status_in(status_in), .irq_evt(irq_evt),
    .irq(irq), .ctrl_en(ctrl_en), .soft_rst(soft_rst), .cfg_regs(cfg_regs)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic rd_reg(input logic [7:0] a, output logic [31:0] d);
    bus.reg_addr = a;
    tick();
    d = bus.reg_rdata;
  endtask
  task automatic wr_reg(input logic [7:0] a, input logic [31:0] d, input int hold);
    bus.reg_addr  = a;
    bus.reg_wdata = d;
    bus.reg_write = 1'b1;
    repeat (hold) tick();
    bus.reg_write = 1'b0;
    tick();
  endtask
  initial begin
    rst = 1'b1; status_in = 32'h1234_ABCD; irq_evt = '0;
    bus.reg_addr = '0; bus.reg_wdata = '0; bus.reg_write = 1'b0;
    repeat (3) tick();
    check("rst_rdata", bus.reg_rdata, 0);
    check("rst_outs", {irq, ctrl_en, soft_rst}, 0);
    check("rst_cfg", cfg_regs[63:0], 0);
    rst = 1'b0;
    rd_reg(8'h00, rd); check("id", rd, 32'h5350_0001);
    rd_reg(8'h01, rd); check("ctrl_rst", rd, 0);
    rd_reg(8'h05, rd); check("cnt_rst", rd, 0);
    tick();
    rd_reg(8'h02, rd); check("status", rd, 32'h1234_ABCD);
    // held write: readback is immediate and the level commits once
    bus.reg_addr = 8'h10; bus.reg_wdata = 32'hA5A5_1234; bus.reg_write = 1'b1;
    tick();
    check("raw_bypass", bus.reg_rdata, 32'hA5A5_1234);
    repeat (4) tick();
    bus.reg_write = 1'b0;
    tick();
    check("cfg0", cfg_regs[31:0], 32'hA5A5_1234);
    rd_reg(8'h05, rd); check("cnt_held", rd, 1);
    wr_reg(8'h04, 32'hFFFF_FF08, 1);
    irq_evt = 8'h08; tick(); irq_evt = '0;
    rd_reg(8'h03, rd);
`ifdef SPI_REG_BANK_IRQ_EN
    check("irq_stat_set", rd, 8);
    check("irq_on", irq, 1);
    rd_reg(8'h04, rd); check("irq_mask", rd, 8);
`else
    check("irq_stat_off", rd, 0);
    check("irq_off", irq, 0);
    rd_reg(8'h04, rd); check("irq_mask_off", rd, 0);
`endif
    bus.reg_addr = 8'h03; bus.reg_wdata = 32'h8; bus.reg_write = 1'b1; irq_evt = 8'h08;
    tick();
    bus.reg_write = 1'b0; irq_evt = '0;
    tick();
    rd_reg(8'h03, rd);
`ifdef SPI_REG_BANK_IRQ_EN
    check("set_wins", rd, 8);
`else
    check("set_wins_off", rd, 0);
`endif
    wr_reg(8'h03, 32'h8, 1);
    rd_reg(8'h03, rd); check("w1c", rd, 0);
    check("irq_clr", irq, 0);
    rd_reg(8'h05, rd); check("cnt4", rd, 4);
    // soft reset with a pending interrupt
    irq_evt = 8'h08; tick(); irq_evt = '0;
    bus.reg_addr = 8'h01; bus.reg_wdata = 32'h3; bus.reg_write = 1'b1;
    tick();
    check("srst_hi", {soft_rst, ctrl_en}, 2'b11);
    bus.reg_write = 1'b0;
    tick();
    check("srst_lo", soft_rst, 0);
    rd_reg(8'h01, rd); check("ctrl_rd", rd, 1);
    rd_reg(8'h05, rd); check("cnt_srst", rd, 0);
    rd_reg(8'h03, rd); check("stat_srst", rd, 0);
    check("irq_srst", irq, 0);
    check("cfg_keep", cfg_regs[31:0], 32'hA5A5_1234);
`ifdef SPI_REG_BANK_IRQ_EN
    rd_reg(8'h04, rd); check("mask_keep", rd, 8);
`endif
    wr_reg(8'h7F, 32'hFFFF_FFFF, 1);
    rd_reg(8'h7F, rd); check("unmapped", rd, 0);
    rd_reg(8'h05, rd); check("cnt_unmapped", rd, 1);
    dut.wr_count = 16'hFFFE;
    wr_reg(8'h7F, 32'h0, 1);
    rd_reg(8'h05, rd); check("cnt_ffff", rd, 32'hFFFF);
    wr_reg(8'h7F, 32'h0, 1);
    rd_reg(8'h05, rd); check("cnt_sat", rd, 32'hFFFF);
    // reset in the middle of a held write
    bus.reg_addr = 8'h11; bus.reg_wdata = 32'h1111_1111; bus.reg_write = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();
    bus.reg_wdata = 32'hDEAD_BEEF;
    rst = 1'b0;
    repeat (3) tick();
    bus.reg_write = 1'b0;
    tick();
    check("rst_write_cfg1", cfg_regs[63:32], 32'hDEAD_BEEF);
    check("rst_write_cfg0", cfg_regs[31:0], 0);
    check("rst_write_ctrl", ctrl_en, 0);
    rd_reg(8'h05, rd); check("rst_write_cnt", rd, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
